// File: rtl/phase_rot_stream.sv
// rtl/phase_rot_stream.sv - per-channel phase-accumulating bitstream rotator with one-entry output register
//
// Purpose: rotates each accepted bitstream word by (channel phase + in_k) mod BITSTREAM,
// right when in_dir=0 and left when in_dir=1. The phase register of the beat's channel
// can be advanced to that sum with in_acc. The result sits in a single registered output
// stage that supports full-rate streaming with backpressure.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input beat handshake (in_ready = !out_valid || out_ready)
//   in_bits, in_k, in_ch         word, phase step, channel index of the input beat
//   in_dir, in_acc               rotate direction (1 = left), commit rotation into phase
//   clr                          synchronous clear of all channel phase registers
//   out_valid/out_ready          output beat handshake
//   out_bits, out_ch, out_rot    rotated word, carried channel, applied rotation amount
module phase_rot_stream #(
  parameter int BITSTREAM = 64,
  parameter int KW        = $clog2(BITSTREAM),
  parameter int NUM_CH    = 4,
  parameter int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITSTREAM-1:0] in_bits,
  input  logic [KW-1:0]        in_k,
  input  logic [CHW-1:0]       in_ch,
  input  logic                 in_dir,
  input  logic                 in_acc,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSTREAM-1:0] out_bits,
  output logic [CHW-1:0]       out_ch,
  output logic [KW-1:0]        out_rot
);

  logic                 out_valid_q;
  logic [BITSTREAM-1:0] out_bits_q;
  logic [CHW-1:0]       out_ch_q;
  logic [KW-1:0]        out_rot_q;
  logic [KW-1:0]        phase_q [NUM_CH];

  logic                 fire_in;
  logic                 fire_out;
  logic                 ch_in_range;
  logic [CHW-1:0]       ch_idx;
  logic [KW-1:0]        phase_sel;
  logic [KW-1:0]        rot_r;
  logic [KW-1:0]        rot_amt;
  logic [KW:0][BITSTREAM-1:0] stage;

  // Handshake: a single output slot, so the block can take a new beat whenever the
  // slot is empty or is being drained this same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid_q && out_ready;

  // Out-of-range channel indices alias onto channel 0 for both read and update.
  assign ch_in_range = ({{(32-CHW){1'b0}}, in_ch} < 32'(NUM_CH));
  assign ch_idx      = ch_in_range ? in_ch : '0;

  always_comb begin
    phase_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CHW'(i)) begin
        phase_sel = phase_q[i];
      end
    end
  end

  // KW-bit add wraps naturally, giving the modulo-BITSTREAM rotation.
  assign rot_r = phase_sel + in_k;

  // A left rotate by r equals a right rotate by (BITSTREAM - r) mod BITSTREAM, so one
  // right-rotating barrel shifter serves both directions; -0 stays 0 (pass-through).
  assign rot_amt = in_dir ? (-rot_r) : rot_r;

  assign stage[0] = in_bits;

  for (genvar s = 0; s < KW; s++) begin : g_rot_stage
    localparam int SH = 1 << s;
    assign stage[s+1] = rot_amt[s] ? {stage[s][SH-1:0], stage[s][BITSTREAM-1:SH]}
                                   : stage[s];
  end

  // Output register: load on accept, empty on drain-without-refill, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_ch_q    <= '0;
      out_rot_q   <= '0;
    end else if (fire_in) begin
      out_valid_q <= 1'b1;
      out_bits_q  <= stage[KW];
      out_ch_q    <= in_ch;
      out_rot_q   <= rot_r;
    end else if (fire_out) begin
      out_valid_q <= 1'b0;
    end
  end

  // Phase registers: clear beats a same-cycle accumulate; the firing beat itself
  // already used the pre-clear phase through rot_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
      end
    end else if (fire_in && in_acc) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == CHW'(i)) begin
          phase_q[i] <= rot_r;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_ch    = out_ch_q;
  assign out_rot   = out_rot_q;

endmodule

// File: tb/tb_phase_rot_stream.sv
// tb/tb_phase_rot_stream.sv - self-checking bench for phase_rot_stream (BITSTREAM=64, NUM_CH=4)
module tb_phase_rot_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bits;
  logic [5:0]  in_k;
  logic [1:0]  in_ch;
  logic        in_dir;
  logic        in_acc;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_bits;
  logic [1:0]  out_ch;
  logic [5:0]  out_rot;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit          m_valid;
  logic [63:0] m_bits;
  logic [1:0]  m_ch;
  logic [5:0]  m_rot;
  int          m_phase [4];
  int          n_acc;

  phase_rot_stream #(
    .BITSTREAM(64),
    .NUM_CH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .in_k(in_k),
    .in_ch(in_ch),
    .in_dir(in_dir),
    .in_acc(in_acc),
    .clr(clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits(out_bits),
    .out_ch(out_ch),
    .out_rot(out_rot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Bit-level rotate: right means out[i] = in[(i+r) mod 64]; left moves in[i] to (i+r) mod 64.
  function automatic logic [63:0] rot_model(input logic [63:0] x, input int r, input bit left);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      if (!left) y[i] = x[(i + r) % 64];
      else       y[(i + r) % 64] = x[i];
    end
    return y;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_bits  = '0;
    m_ch    = '0;
    m_rot   = '0;
    for (int i = 0; i < 4; i++) m_phase[i] = 0;
  endtask

  task automatic drive(input bit v, input logic [63:0] b, input int k, input int ch,
                       input bit dir, input bit acc, input bit c, input bit ordy);
    in_valid  = v;
    in_bits   = b;
    in_k      = 6'(k);
    in_ch     = 2'(ch);
    in_dir    = dir;
    in_acc    = acc;
    clr       = c;
    out_ready = ordy;
  endtask

  // One clock with the currently driven inputs; checks handshake and output stage.
  task automatic cycle();
    bit exp_ready;
    bit fire;
    int ch;
    int r;
    @(negedge clk);
    exp_ready = !m_valid || out_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    fire = in_valid && exp_ready;
    ch = (int'(in_ch) < 4) ? int'(in_ch) : 0;
    r  = (m_phase[ch] + int'(in_k)) % 64;
    @(posedge clk);
    if (fire) begin
      m_valid = 1;
      m_bits  = rot_model(in_bits, r, in_dir);
      m_ch    = in_ch;
      m_rot   = 6'(r);
      n_acc++;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) m_phase[i] = 0;
    end else if (fire && in_acc) begin
      m_phase[ch] = r;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_bits", out_bits, m_bits);
      chk("out_ch", 64'(out_ch), 64'(m_ch));
      chk("out_rot", 64'(out_rot), 64'(m_rot));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, 0, 0, 1);
    model_reset();
    n_acc = 0;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_bits", out_bits, 64'd0);
    chk("rst_out_rot", 64'(out_rot), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Right rotate on ch0, no accumulate
    drive(1, 64'h0000_0000_0000_00F0, 4, 0, 0, 0, 0, 1);
    cycle();
    chk("r_rot_bits", out_bits, 64'h0000_0000_0000_000F);
    chk("r_rot_amt", 64'(out_rot), 64'd4);
    drive(1, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("r_rot_ch0_phase", 64'(out_rot), 64'd0);
    chk("r_rot_k0_pass", out_bits, 64'h1234_5678_9ABC_DEF0);

    // Left rotate with wrap of the MSB
    drive(1, 64'h8000_0000_0000_0001, 1, 0, 1, 0, 0, 1);
    cycle();
    chk("l_rot_bits", out_bits, 64'h0000_0000_0000_0003);
    drive(1, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 1, 0, 0, 1);
    cycle();
    chk("l_rot_k0_pass", out_bits, 64'hDEAD_BEEF_0BAD_F00D);

    // Accumulate wrap on ch1
    drive(1, 64'hA5A5_0000_FFFF_1234, 40, 1, 0, 1, 0, 1);
    cycle();
    chk("acc_rot1", 64'(out_rot), 64'd40);
    cycle();
    chk("acc_rot2", 64'(out_rot), 64'd16);
    for (int c = 0; c < 4; c++) begin
      drive(1, 64'(c) * 64'h0101_0101_0101_0101, 0, c, 0, 0, 0, 1);
      cycle();
      chk($sformatf("acc_phase_ch%0d", c), 64'(out_rot), (c == 1) ? 64'd16 : 64'd0);
    end

    // clr together with an accumulating beat on ch2
    drive(1, 64'h0F0F_0F0F_0F0F_0F0F, 10, 2, 0, 1, 0, 1);
    cycle();
    drive(1, 64'hFFFF_0000_FFFF_0000, 5, 2, 1, 1, 1, 1);
    cycle();
    chk("clr_rot", 64'(out_rot), 64'd15);
    drive(1, 64'h1111_2222_3333_4444, 0, 2, 0, 0, 0, 1);
    cycle();
    chk("clr_phase2", 64'(out_rot), 64'd0);
    drive(1, 64'h5555_6666_7777_8888, 0, 1, 0, 0, 0, 1);
    cycle();
    chk("clr_phase1", 64'(out_rot), 64'd0);

    // Backpressure: output stalled five cycles with a beat waiting
    drive(1, {$urandom, $urandom}, 9, 3, 1, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_bits = {$urandom, $urandom};
      in_k    = 6'($urandom_range(0, 63));
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // Back-to-back random stream, full throughput
    for (int c = 0; c < 40; c++) begin
      drive(1, {$urandom, $urandom}, $urandom_range(0, 63), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 0, 1);
      cycle();
    end

    // Random stream with random valid/ready gaps and occasional clr, until 100 beats accepted
    n_acc = 0;
    for (int c = 0; c < 2000 && n_acc < 100; c++) begin
      drive($urandom_range(0, 7) != 0, {$urandom, $urandom}, $urandom_range(0, 63),
            $urandom_range(0, 3), 1'($urandom), 1'($urandom),
            $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
      cycle();
    end
    chk("rand_beats_accepted", 64'(n_acc), 64'd100);
    drive(0, '0, 0, 0, 0, 0, 0, 1);
    cycle();

    // Reset asserted while a beat sits in the output register
    drive(0, '0, 0, 0, 0, 0, 1, 1);
    cycle();
    drive(1, 64'hCAFE_F00D_1234_5678, 9, 1, 0, 1, 0, 1);
    cycle();
    drive(1, 64'h0000_0000_0000_00FF, 3, 1, 0, 1, 0, 0);
    cycle();
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_bits", out_bits, 64'd0);
    chk("mid_rst_rot", 64'(out_rot), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 64'h0000_0000_0000_0080, 7, 1, 0, 0, 0, 1);
    cycle();
    chk("post_rst_rot", 64'(out_rot), 64'd7);
    chk("post_rst_bits", out_bits, 64'h0000_0000_0000_0001);
    drive(0, '0, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("idle_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
